// File: rtl/fetch_inject_arbiter.sv
// fetch_inject_arbiter
//   Fetch-side partner of the microcode multiply sequencer. Owns the PC,
//   drives the instruction memory address and registers the IF/ID
//   instruction. While a multiply runs, fetch is frozen. The already-fetched
//   next instruction is parked, the sequencer's injected words pass through,
//   and the parked instruction is then replayed before fetching resumes.
//
// Optional feature (macro INJECT_WATCHDOG_EN):
//   When defined, a watchdog counts INJECT cycles. After WDOG_CYC cycles
//   without release it sets the sticky inject_timeout flag and forces REPLAY.
//   When undefined, no counter is built and inject_timeout is tied low.
//
// Ports:
//   clk                rising-edge clock
//   rst                synchronous active-low reset
//   imem_addr          instruction memory address (the PC register)
//   imem_rdata         instruction at imem_addr, valid in the same cycle
//   stall              hazard hold of PC and IF/ID (RUN/REPLAY only)
//   branch_taken       redirect from execute
//   branch_target      redirect address
//   start_mul          one-cycle pulse: a MUL sits in ID
//   ucode_instr        injected instruction from the sequencer
//   ucode_mux_ctrl     ucode_instr is valid this cycle
//   ucode_mul_release  sequencer done; one-cycle pulse
//   if_instr           registered instruction to ID
//   if_pc              registered PC of if_instr (injected words carry the MUL's PC)
//   if_valid           registered; low when if_instr is a NOP bubble
//   mul_busy           high in INJECT and REPLAY
//   inject_timeout     sticky watchdog error

module fetch_inject_arbiter #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = {ADDR_W{1'b0}},
    parameter int unsigned        PC_STEP   = 4,
    parameter logic [31:0]        NOP_INSTR = 32'hC800_0000,
    parameter int unsigned        WDOG_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              start_mul,
    input  logic [31:0]       ucode_instr,
    input  logic              ucode_mux_ctrl,
    input  logic              ucode_mul_release,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              mul_busy,
    output logic              inject_timeout
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_INJECT = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [31:0]       if_instr_r, if_instr_s;
    logic [ADDR_W-1:0] if_pc_r, if_pc_s;
    logic              if_valid_r, if_valid_s;
    logic [31:0]       replay_instr_r, replay_instr_s;
    logic [ADDR_W-1:0] replay_pc_r, replay_pc_s;
    logic              mul_busy_r;

`ifdef INJECT_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_cnt_r, wdog_cnt_s;
    logic              timeout_r, timeout_s;
`else
    // WDOG_CYC only matters when the watchdog is built.
    logic wdog_unused_s;
    assign wdog_unused_s = ^WDOG_CYC;
`endif

    // Next-state and next-output decode for the RUN / INJECT / REPLAY sequence.
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        if_instr_s     = if_instr_r;
        if_pc_s        = if_pc_r;
        if_valid_s     = if_valid_r;
        replay_instr_s = replay_instr_r;
        replay_pc_s    = replay_pc_r;
`ifdef INJECT_WATCHDOG_EN
        wdog_cnt_s     = wdog_cnt_r;
        timeout_s      = timeout_r;
`endif
        case (state_r)
            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect wins; a same-cycle start_mul is dropped.
                    pc_s       = branch_target;
                    if_instr_s = NOP_INSTR;
                    if_valid_s = 1'b0;
                end else if (stall) begin
                    pc_s = pc_r;
                end else if (start_mul) begin
                    // Park the word already fetched behind the MUL; if_pc keeps
                    // the MUL's PC so injected words are attributed to it.
                    replay_instr_s = imem_rdata;
                    replay_pc_s    = pc_r;
                    if_instr_s     = NOP_INSTR;
                    if_valid_s     = 1'b0;
                    state_s        = ST_INJECT;
`ifdef INJECT_WATCHDOG_EN
                    wdog_cnt_s     = {WDOG_W{1'b0}};
`endif
                end else begin
                    if_instr_s = imem_rdata;
                    if_pc_s    = pc_r;
                    if_valid_s = 1'b1;
                    pc_s       = pc_r + ADDR_W'(PC_STEP);
                end
            end
            ST_INJECT: begin
                // The sequencer cannot be held, so stall and branch are ignored.
`ifdef INJECT_WATCHDOG_EN
                wdog_cnt_s = wdog_cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
`endif
                if (ucode_mul_release) begin
                    if_instr_s = NOP_INSTR;
                    if_valid_s = 1'b0;
                    state_s    = ST_REPLAY;
`ifdef INJECT_WATCHDOG_EN
                end else if (wdog_cnt_r == WDOG_W'(WDOG_CYC - 1)) begin
                    if_instr_s = NOP_INSTR;
                    if_valid_s = 1'b0;
                    timeout_s  = 1'b1;
                    state_s    = ST_REPLAY;
`endif
                end else if (ucode_mux_ctrl) begin
                    if_instr_s = ucode_instr;
                    if_valid_s = 1'b1;
                end else begin
                    if_instr_s = NOP_INSTR;
                    if_valid_s = 1'b0;
                end
            end
            ST_REPLAY: begin
                if (branch_taken) begin
                    // The parked instruction is on the wrong path; drop it.
                    pc_s       = branch_target;
                    if_instr_s = NOP_INSTR;
                    if_valid_s = 1'b0;
                    state_s    = ST_RUN;
                end else if (stall) begin
                    pc_s = pc_r;
                end else begin
                    if_instr_s = replay_instr_r;
                    if_pc_s    = replay_pc_r;
                    if_valid_s = 1'b1;
                    pc_s       = replay_pc_r + ADDR_W'(PC_STEP);
                    state_s    = ST_RUN;
                end
            end
            default: begin
                state_s    = ST_RUN;
                if_instr_s = NOP_INSTR;
                if_valid_s = 1'b0;
            end
        endcase
    end

    // State, PC, IF/ID and replay registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_RUN;
            pc_r           <= RESET_PC;
            if_instr_r     <= NOP_INSTR;
            if_pc_r        <= {ADDR_W{1'b0}};
            if_valid_r     <= 1'b0;
            replay_instr_r <= 32'h0000_0000;
            replay_pc_r    <= {ADDR_W{1'b0}};
            mul_busy_r     <= 1'b0;
`ifdef INJECT_WATCHDOG_EN
            wdog_cnt_r     <= {WDOG_W{1'b0}};
            timeout_r      <= 1'b0;
`endif
        end else begin
            state_r        <= state_s;
            pc_r           <= pc_s;
            if_instr_r     <= if_instr_s;
            if_pc_r        <= if_pc_s;
            if_valid_r     <= if_valid_s;
            replay_instr_r <= replay_instr_s;
            replay_pc_r    <= replay_pc_s;
            mul_busy_r     <= (state_s != ST_RUN);
`ifdef INJECT_WATCHDOG_EN
            wdog_cnt_r     <= wdog_cnt_s;
            timeout_r      <= timeout_s;
`endif
        end
    end

    assign imem_addr = pc_r;
    assign if_instr  = if_instr_r;
    assign if_pc     = if_pc_r;
    assign if_valid  = if_valid_r;
    assign mul_busy  = mul_busy_r;
`ifdef INJECT_WATCHDOG_EN
    assign inject_timeout = timeout_r;
`else
    assign inject_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_inject_arbiter.sv
// Self-checking bench for fetch_inject_arbiter (default build, watchdog off).
// A small behavioural model (phase number plus a queue of parked
// instructions) predicts the outputs. One process compares them on every
// falling edge. Literal pins in the stimulus sequence anchor the model.
module tb_fetch_inject_arbiter;

    localparam logic [31:0] NOP = 32'hC800_0000;
    localparam logic [31:0] TAG = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        start_mul;
    logic [31:0] ucode_instr;
    logic        ucode_mux_ctrl;
    logic        ucode_mul_release;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        mul_busy;
    logic        inject_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // model state: phase 0 = fetching, 1 = injecting, 2 = replay pending
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid;
    int          m_phase;
    logic [31:0] sv_word[$];
    logic [31:0] sv_pc[$];

    // instruction memory: every word is its own address tagged in the top bits
    assign imem_rdata = imem_addr | TAG;

    always #5 clk = ~clk;

    fetch_inject_arbiter #(
        .ADDR_W(32), .RESET_PC(32'h0000_0000), .PC_STEP(4),
        .NOP_INSTR(32'hC800_0000), .WDOG_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .start_mul(start_mul), .ucode_instr(ucode_instr), .ucode_mux_ctrl(ucode_mux_ctrl),
        .ucode_mul_release(ucode_mul_release), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .mul_busy(mul_busy), .inject_timeout(inject_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock edge worth of behaviour, from the bench's inputs only
    task automatic model_step();
        if (!rst) begin
            m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0; m_phase = 0;
            sv_word.delete(); sv_pc.delete();
        end else if (m_phase == 0) begin
            if (branch_taken) begin
                m_pc = branch_target; m_instr = NOP; m_valid = 1'b0;
            end else if (!stall) begin
                if (start_mul) begin
                    sv_word.push_back(m_pc | TAG); sv_pc.push_back(m_pc);
                    m_instr = NOP; m_valid = 1'b0; m_phase = 1;
                end else begin
                    m_instr = m_pc | TAG; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
                end
            end
        end else if (m_phase == 1) begin
            if (ucode_mul_release) begin
                m_instr = NOP; m_valid = 1'b0; m_phase = 2;
            end else begin
                m_instr = ucode_mux_ctrl ? ucode_instr : NOP;
                m_valid = ucode_mux_ctrl;
            end
        end else begin
            if (branch_taken) begin
                m_pc = branch_target; m_instr = NOP; m_valid = 1'b0; m_phase = 0;
                sv_word.delete(); sv_pc.delete();
            end else if (!stall) begin
                m_instr = sv_word.pop_front(); m_ipc = sv_pc.pop_front();
                m_valid = 1'b1; m_pc = m_ipc + 32'd4; m_phase = 0;
            end
        end
    endtask

    // compare DUT against the model on every falling edge once it is meaningful
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", if_pc, m_ipc);
            chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
            chk("mul_busy", {31'd0, mul_busy}, {31'd0, (m_phase != 0)});
            chk("inject_timeout", {31'd0, inject_timeout}, 32'd0);
        end
    end

    task automatic run(input logic r, input logic b, input logic [31:0] t, input logic s,
                       input logic m, input logic mc, input logic [31:0] ui, input logic rl);
        rst = r; branch_taken = b; branch_target = t; stall = s;
        start_mul = m; ucode_mux_ctrl = mc; ucode_instr = ui; ucode_mul_release = rl;
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0;
        start_mul = 1'b0; ucode_instr = 32'h0; ucode_mux_ctrl = 1'b0; ucode_mul_release = 1'b0;

        // reset
        run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pin_rst_instr", if_instr, 32'hC800_0000);
        chk("pin_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("pin_rst_pc", imem_addr, 32'h0);
        chk("pin_rst_ifpc", if_pc, 32'h0);

        // sequential fetch then 2-cycle stall
        idle(); idle(); idle();
        chk("pin_seq_ifpc", if_pc, 32'h8);
        chk("pin_seq_instr", if_instr, 32'hA000_0008);
        run(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pin_stall_ifpc", if_pc, 32'h8);
        chk("pin_stall_pc", imem_addr, 32'hC);
        idle();
        chk("pin_fetch_c", if_pc, 32'hC);

        // multiply with PC=0x10: MOV, ADD x3 (stall/branch/start_mul ignored), release
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("pin_mul_nop", if_instr, 32'hC800_0000);
        chk("pin_mul_busy", {31'd0, mul_busy}, 32'd1);
        chk("pin_mul_pcfrz", imem_addr, 32'h10);
        run(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h1000_0001, 1'b0);
        chk("pin_mov", if_instr, 32'h1000_0001);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2000_0002, 1'b0);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000_0003, 1'b0);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000_0004, 1'b0);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("pin_rel_nop", if_instr, 32'hC800_0000);
        run(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        chk("pin_replay_w", if_instr, 32'hA000_0010);
        chk("pin_replay_pc", if_pc, 32'h10);
        chk("pin_resume_addr", imem_addr, 32'h14);
        idle();

        // immediate-0 multiply: SUB then release
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3000_0003, 1'b0);
        chk("pin_sub", if_instr, 32'h3000_0003);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle();
        chk("pin_imm0_replay", if_instr, 32'hA000_0018);
        chk("pin_imm0_addr", imem_addr, 32'h1C);

        // branch with start_mul in RUN
        run(1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("pin_br_pc", imem_addr, 32'h80);
        chk("pin_br_busy", {31'd0, mul_busy}, 32'd0);
        idle();
        chk("pin_br_fetch", if_pc, 32'h80);

        // branch in REPLAY drops the parked instruction
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        run(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pin_rbr_pc", imem_addr, 32'h40);
        idle();
        chk("pin_rbr_fetch", if_instr, 32'hA000_0040);

        // reset while injecting
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        run(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4000_0004, 1'b0);
        run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4000_0005, 1'b0);
        chk("pin_midrst_pc", imem_addr, 32'h0);
        chk("pin_midrst_busy", {31'd0, mul_busy}, 32'd0);
        idle(); idle();
        chk("pin_after_rst", if_pc, 32'h4);

        // PC wrap
        run(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        chk("pin_wrap_addr", imem_addr, 32'h0);
        idle();
        chk("pin_wrap_ifpc", if_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
